// File: rtl/ptp_sync_tx.sv
// ptp_sync_tx -- master-side PTP Sync frame generator on the 134-bit UM bus.
// A programmable period timer requests a Sync; the FSM then streams a
// 6-beat packet (2 metadata beats + 64-byte L2 PTP frame) stamped from
// precision_time. Define PTP_TWO_STEP_EN for two-step operation: the Sync
// carries a zero timestamp with the twoStep flag and is followed back-to-back
// by a Follow_Up carrying the captured time. Default build is one-step.
module ptp_sync_tx #(
  parameter int unsigned PORT_NUM = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [31:0]  sync_interval,
  input  logic [47:0]  precision_time,
  input  logic [47:0]  device_mac,
  input  logic [7:0]   out_port,
  input  logic         out_ready,
  output logic         out_data_wr,
  output logic [133:0] out_data,
  output logic         out_data_valid_wr,
  output logic         out_data_valid,
  output logic [15:0]  seq_id,
  output logic [15:0]  missed_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
`ifdef PTP_TWO_STEP_EN
    ST_FUP  = 2'd2,
`endif
    ST_GAP  = 2'd3
  } state_e;

  localparam logic [15:0] PORT_ID     = 16'(PORT_NUM);
  localparam logic [47:0] PTP_DST_MAC = 48'h011B_1900_0000;
  localparam logic [15:0] PTP_ETYPE   = 16'h88F7;
  localparam logic [2:0]  LAST_BEAT   = 3'd5;

  state_e        state_q, state_d;
  logic [2:0]    beat_q, beat_d;
  logic [31:0]   timer_q, timer_d;
  logic          pending_q, pending_d;
  logic [15:0]   missed_cnt_q, missed_cnt_d;
  logic [15:0]   seq_id_q, seq_id_d;
  logic [47:0]   ts_q, ts_d;
  logic          wr_q, wr_d;
  logic [133:0]  data_q, data_d;
  logic          vld_q, vld_d;

  logic          run;
  logic          expire;
  logic          take;
  logic          in_flight;

  logic [3:0]    msg_type;
  logic [7:0]    ctrl_field;
  logic [15:0]   flags;
  logic [47:0]   ts_field;
  logic [127:0]  payload;
  logic [1:0]    beat_hdr;
  logic          beat_active;

  // Period timer: free-runs 0..sync_interval-1 while generation is allowed.
  always_comb begin
    run     = enable && (sync_interval != 32'd0);
    // The >= compare also catches a period shortened below the current count.
    expire  = run && (timer_q >= (sync_interval - 32'd1));
    timer_d = '0;
    if (run && !expire) begin
      timer_d = timer_q + 32'd1;
    end
  end

  // Request bookkeeping: expiries that cannot launch coalesce into pending.
  always_comb begin
    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned; a missing default infers a latch.
    pending_d    = pending_q;
    missed_cnt_d = missed_cnt_q;
    in_flight    = (state_q != ST_IDLE);
    take         = (state_q == ST_IDLE) && pending_q && out_ready && run;
    if (!run) begin
      pending_d = 1'b0;
    end else if (expire) begin
      // An expiry in the launch cycle simply re-arms pending; it is not lost.
      pending_d = 1'b1;
      if (((pending_q && !take) || in_flight) && (missed_cnt_q != 16'hFFFF)) begin
        missed_cnt_d = missed_cnt_q + 16'd1;
      end
    end else if (take) begin
      pending_d = 1'b0;
    end
  end

  // Packet sequencer: state/beat name the beat shown on the bus next cycle.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    seq_id_d = seq_id_q;
    ts_d     = ts_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d  = ST_SYNC;
          beat_d   = 3'd0;
          seq_id_d = seq_id_q + 16'd1;
        end
      end
      ST_SYNC: begin
        // Time is taken while the Sync head beat is on the bus.
        if (beat_q == 3'd0) begin
          ts_d = precision_time;
        end
        if (beat_q == LAST_BEAT) begin
          beat_d = 3'd0;
`ifdef PTP_TWO_STEP_EN
          state_d = ST_FUP;
`else
          state_d = ST_GAP;
`endif
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end
`ifdef PTP_TWO_STEP_EN
      ST_FUP: begin
        if (beat_q == LAST_BEAT) begin
          beat_d  = 3'd0;
          state_d = ST_GAP;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end
`endif
      ST_GAP: begin
        state_d = ST_IDLE;
        beat_d  = 3'd0;
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = 3'd0;
      end
    endcase
  end

  // Beat builder: renders the next bus word from the next state and beat.
  always_comb begin
    msg_type   = 4'h0;
    ctrl_field = 8'h00;
    flags      = 16'h0000;
    ts_field   = ts_q;
`ifdef PTP_TWO_STEP_EN
    if (state_d == ST_FUP) begin
      msg_type   = 4'h8;
      ctrl_field = 8'h02;
    end else begin
      flags    = 16'h0200;
      ts_field = 48'd0;
    end
`endif
    unique case (beat_d)
      3'd0:    payload = {16'd64, out_port, 104'd0};
      3'd2:    payload = {PTP_DST_MAC, device_mac, PTP_ETYPE, 4'h0, msg_type, 8'h02};
      3'd3:    payload = {16'd44, 8'h00, 8'h00, flags, 64'd0, 16'd0};
      3'd4:    payload = {16'd0, device_mac[47:24], 8'hFF, 8'hFE, device_mac[23:0],
                          PORT_ID, seq_id_d, ctrl_field, 8'h00};
      3'd5:    payload = {32'd0, ts_field, 48'd0};
      default: payload = '0;
    endcase
    if (beat_d == 3'd0) begin
      beat_hdr = 2'b01;
    end else if (beat_d == LAST_BEAT) begin
      beat_hdr = 2'b10;
    end else begin
      beat_hdr = 2'b11;
    end
`ifdef PTP_TWO_STEP_EN
    beat_active = (state_d == ST_SYNC) || (state_d == ST_FUP);
`else
    beat_active = (state_d == ST_SYNC);
`endif
    wr_d   = beat_active;
    vld_d  = beat_active && (beat_d == LAST_BEAT);
    data_d = beat_active ? {beat_hdr, 4'h0, payload} : '0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would create ordering races.
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      timer_q      <= '0;
      pending_q    <= 1'b0;
      missed_cnt_q <= '0;
      seq_id_q     <= '0;
      ts_q         <= '0;
      wr_q         <= 1'b0;
      data_q       <= '0;
      vld_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      timer_q      <= timer_d;
      pending_q    <= pending_d;
      missed_cnt_q <= missed_cnt_d;
      seq_id_q     <= seq_id_d;
      ts_q         <= ts_d;
      wr_q         <= wr_d;
      data_q       <= data_d;
      vld_q        <= vld_d;
    end
  end

  assign out_data_wr       = wr_q;
  assign out_data          = data_q;
  assign out_data_valid_wr = vld_q;
  assign out_data_valid    = vld_q;
  assign seq_id            = seq_id_q;
  assign missed_cnt        = missed_cnt_q;

endmodule

// File: tb/tb_ptp_sync_tx.sv
// tb_ptp_sync_tx -- self-checking bench for ptp_sync_tx. A frame-level model
// (queue of pending beats, byte-array frame image) predicts every output on
// every cycle; directed phases pin the model with literal expectations.
// Build with +define+PTP_TWO_STEP_EN to exercise the two-step variant.
module tb_ptp_sync_tx;

`ifdef PTP_TWO_STEP_EN
  localparam bit TWO = 1'b1;
`else
  localparam bit TWO = 1'b0;
`endif
  localparam int PKT_HEADS = TWO ? 2 : 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [31:0]  sync_interval;
  logic [47:0]  precision_time;
  logic [47:0]  device_mac;
  logic [7:0]   out_port;
  logic         out_ready;
  logic         out_data_wr;
  logic [133:0] out_data;
  logic         out_data_valid_wr;
  logic         out_data_valid;
  logic [15:0]  seq_id;
  logic [15:0]  missed_cnt;

  always #5 clk = ~clk;

  ptp_sync_tx #(.PORT_NUM(1)) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .sync_interval     (sync_interval),
    .precision_time    (precision_time),
    .device_mac        (device_mac),
    .out_port          (out_port),
    .out_ready         (out_ready),
    .out_data_wr       (out_data_wr),
    .out_data          (out_data),
    .out_data_valid_wr (out_data_valid_wr),
    .out_data_valid    (out_data_valid),
    .seq_id            (seq_id),
    .missed_cnt        (missed_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {K_NONE, K_SYNC, K_FUP, K_GAP} kind_e;
  typedef struct {
    kind_e kind;
    int    idx;
  } slot_t;

  slot_t        q[$];
  slot_t        cur;
  int           m_tmr;
  bit           m_pend;
  int           m_missed;
  logic [15:0]  m_seq;
  logic [47:0]  m_ts;
  logic [133:0] exp_data;
  logic         exp_wr, exp_vld;
  logic [15:0]  exp_seq, exp_missed;
  bit           checking = 1'b0;
  int           force_cnt = 0;
  int           force_seen = 0;
  logic [15:0]  force_seq;
  int           force_missed;
  int           n_heads = 0;
  int           n_beats = 0;
  bit           cap_en = 1'b0;
  int           cap_n = 0;
  logic [133:0] cap [12];

  // Render one bus word from a full 64-byte frame image.
  function automatic logic [133:0] render(input slot_t s, input logic [47:0] mac,
                                          input logic [7:0] port, input logic [15:0] seq,
                                          input logic [47:0] ts);
    logic [7:0]   fr [64];
    logic [47:0]  dst;
    logic [63:0]  cid;
    logic [79:0]  tsf;
    logic [15:0]  flg;
    logic [15:0]  pn;
    logic [127:0] w;
    logic [1:0]   hdr;
    bit           fup;
    if (s.kind != K_SYNC && s.kind != K_FUP) return '0;
    fup = (s.kind == K_FUP);
    dst = 48'h011B19000000;
    cid = {mac[47:24], 8'hFF, 8'hFE, mac[23:0]};
    flg = (!fup && TWO) ? 16'h0200 : 16'h0000;
    tsf = (!fup && TWO) ? 80'd0 : {32'd0, ts};
    pn  = 16'd1;
    for (int i = 0; i < 64; i++) fr[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fr[i]     = dst[47-8*i -: 8];
      fr[6+i]   = mac[47-8*i -: 8];
    end
    fr[12] = 8'h88;
    fr[13] = 8'hF7;
    fr[14] = fup ? 8'h08 : 8'h00;
    fr[15] = 8'h02;
    fr[17] = 8'd44;
    fr[20] = flg[15:8];
    fr[21] = flg[7:0];
    for (int i = 0; i < 8; i++) fr[34+i] = cid[63-8*i -: 8];
    fr[42] = pn[15:8];
    fr[43] = pn[7:0];
    fr[44] = seq[15:8];
    fr[45] = seq[7:0];
    fr[46] = fup ? 8'h02 : 8'h00;
    for (int i = 0; i < 10; i++) fr[48+i] = tsf[79-8*i -: 8];
    w = '0;
    if (s.idx == 0) begin
      w = {16'd64, port, 104'd0};
    end else if (s.idx >= 2) begin
      for (int i = 0; i < 16; i++) w[127-8*i -: 8] = fr[(s.idx-2)*16 + i];
    end
    hdr = (s.idx == 0) ? 2'b01 : ((s.idx == 5) ? 2'b10 : 2'b11);
    return {hdr, 4'h0, w};
  endfunction

  // Compare process plus model advance, once per cycle away from the edge.
  always @(negedge clk) begin
    bit run, expire, in_flight, take;
    if (force_cnt != force_seen) begin
      force_seen = force_cnt;
      m_seq      = force_seq;
      m_missed   = force_missed;
      exp_seq    = force_seq;
      exp_missed = force_missed[15:0];
    end
    if (checking) begin
      check("out_data_wr", out_data_wr, exp_wr);
      check("out_data", out_data, exp_data);
      check("out_data_valid_wr", out_data_valid_wr, exp_vld);
      check("out_data_valid", out_data_valid, exp_vld);
      check("seq_id", seq_id, exp_seq);
      check("missed_cnt", missed_cnt, exp_missed);
    end
    if (out_data_wr) n_beats++;
    if (out_data_wr && out_data[133:132] == 2'b01) n_heads++;
    if (cap_en && out_data_wr && cap_n < 12) begin
      cap[cap_n] = out_data;
      cap_n++;
    end
    if (rst) begin
      q.delete();
      cur      = '{K_NONE, 0};
      m_tmr    = 0;
      m_pend   = 1'b0;
      m_missed = 0;
      m_seq    = 16'd0;
      m_ts     = 48'd0;
      exp_data = '0;
      exp_wr   = 1'b0;
      exp_vld  = 1'b0;
      exp_seq  = 16'd0;
      exp_missed = 16'd0;
    end else begin
      if (cur.kind == K_SYNC && cur.idx == 0) m_ts = precision_time;
      in_flight = (cur.kind != K_NONE);
      run       = enable && (sync_interval != 0);
      take      = !in_flight && m_pend && out_ready && run;
      expire    = 1'b0;
      if (!run) begin
        m_tmr  = 0;
        m_pend = 1'b0;
      end else begin
        if (longint'(m_tmr) + 1 >= longint'(sync_interval)) begin
          expire = 1'b1;
          m_tmr  = 0;
        end else begin
          m_tmr++;
        end
        if (expire) begin
          if (((m_pend && !take) || in_flight) && m_missed < 65535) m_missed++;
          m_pend = 1'b1;
        end else if (take) begin
          m_pend = 1'b0;
        end
      end
      if (take) begin
        for (int i = 0; i < 6; i++) q.push_back('{K_SYNC, i});
        if (TWO) for (int i = 0; i < 6; i++) q.push_back('{K_FUP, i});
        q.push_back('{K_GAP, 0});
      end
      cur = (q.size() != 0) ? q.pop_front() : '{K_NONE, 0};
      if (cur.kind == K_SYNC && cur.idx == 0) m_seq = m_seq + 16'd1;
      exp_data   = render(cur, device_mac, out_port, m_seq, m_ts);
      exp_wr     = (cur.kind == K_SYNC || cur.kind == K_FUP);
      exp_vld    = exp_wr && (cur.idx == 5);
      exp_seq    = m_seq;
      exp_missed = m_missed[15:0];
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_head(input string name, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_data_wr && out_data[133:132] == 2'b01) begin
        found = 1'b1;
        break;
      end
    end
    check(name, found, 1'b1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    int h0, b0;
    logic [63:0] rnd;
    rst = 1'b1; enable = 1'b0; sync_interval = 32'd0; precision_time = 48'd0;
    device_mac = 48'd0; out_port = 8'd0; out_ready = 1'b0;
    cycles(3);
    checking = 1'b1;
    @(negedge clk);
    check("reset_wr", out_data_wr, 1'b0);
    check("reset_data", out_data, 134'd0);
    check("reset_seq", seq_id, 16'd0);
    check("reset_missed", missed_cnt, 16'd0);

    // Phase A: nominal periodic Sync, fixed timestamp for literal pins.
    @(posedge clk); #1;
    rst = 1'b0; enable = 1'b1; sync_interval = 32'd100; out_ready = 1'b1;
    device_mac = 48'h000A35010203; out_port = 8'h05;
    precision_time = 48'h0000_1234_5678; cap_en = 1'b1;
    h0 = n_heads;
    cycles(330);
    check("A_seq_after_3", seq_id, 16'd3);
    check("A_heads", n_heads - h0, 3 * PKT_HEADS);
    check("A_hdrs", {cap[0][133:132], cap[1][133:132], cap[2][133:132], cap[3][133:132],
                     cap[4][133:132], cap[5][133:132]}, 12'b01_11_11_11_11_10);
    check("A_md0", cap[0][127:104], {16'd64, 8'h05});
    check("A_dst_mac", cap[2][127:80], 48'h011B19000000);
    check("A_src_mac", cap[2][79:32], 48'h000A35010203);
    check("A_ethertype", cap[2][31:16], 16'h88F7);
    check("A_clock_id", cap[4][111:48], 64'h000A35FFFE010203);
    check("A_port_num", cap[4][47:32], 16'd1);
    check("A_seq_field", cap[4][31:16], 16'd1);
`ifdef PTP_TWO_STEP_EN
    check("A_sync_flags", cap[3][95:80], 16'h0200);
    check("A_sync_ts", cap[5][127:48], 80'd0);
    check("A_fup_type", cap[8][15:8], 8'h08);
    check("A_fup_seq", cap[10][31:16], 16'd1);
    check("A_fup_ctrl", cap[10][15:8], 8'h02);
    check("A_fup_ts", cap[11][127:48], 80'h0000_0000_0000_1234_5678);
    check("A_fup_tail", cap[11][133:132], 2'b10);
`else
    check("A_sync_flags", cap[3][95:80], 16'h0000);
    check("A_sync_ts", cap[5][127:48], 80'h0000_0000_0000_1234_5678);
`endif
    cap_en = 1'b0;

    // Phase B: downstream stalled for 350 cycles, then released.
    out_ready = 1'b0;
    pulse_reset();
    b0 = n_beats; h0 = n_heads;
    cycles(350);
    check("B_no_beats", n_beats - b0, 0);
    check("B_missed", missed_cnt, 16'd2);
    out_ready = 1'b1;
    h0 = n_heads;
    cycles(40);
    check("B_one_sync", n_heads - h0, PKT_HEADS);

    // Phase C: sequenceId wrap and missed_cnt saturation.
    enable = 1'b0;
    cycles(16);
    force_seq = 16'hFFFF; force_missed = 16'hFFFE;
    force dut.seq_id_q = 16'hFFFF;
    force dut.missed_cnt_q = 16'hFFFE;
    force_cnt++;
    cycles(2);
    release dut.seq_id_q;
    release dut.missed_cnt_q;
    enable = 1'b1; sync_interval = 32'd20; out_ready = 1'b1;
    wait_head("C_head_timeout", 100);
    check("C_seq_wrap", seq_id, 16'h0000);
    @(posedge clk); #1;
    out_ready = 1'b0;
    cycles(100);
    check("C_missed_sat", missed_cnt, 16'hFFFF);
    cycles(60);
    check("C_missed_hold", missed_cnt, 16'hFFFF);

    // Phase E: reset while beat 3 of a Sync is on the bus.
    pulse_reset();
    out_ready = 1'b1; sync_interval = 32'd30;
    wait_head("E_head_timeout", 100);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("E_rst_wr", out_data_wr, 1'b0);
    check("E_rst_data", out_data, 134'd0);
    check("E_rst_vld", out_data_valid_wr, 1'b0);
    check("E_rst_seq", seq_id, 16'd0);
    @(posedge clk); #1 rst = 1'b0;
    wait_head("E_restart_timeout", 100);
    check("E_restart_seq", seq_id, 16'd1);

    // Phase D: randomized traffic against the model.
    @(posedge clk); #1;
    for (int i = 0; i < 4000; i++) begin
      precision_time = precision_time + 48'd1 + 48'($urandom_range(0, 3));
      if ($urandom_range(0, 14) == 0) out_ready = ~out_ready;
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if ($urandom_range(0, 199) == 0)
        sync_interval = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(3, 40));
      if ($urandom_range(0, 63) == 0) begin
        rnd = {$urandom(), $urandom()};
        device_mac = rnd[47:0];
        out_port   = rnd[55:48];
      end
      rst = ($urandom_range(0, 699) == 0);
      cycles(1);
    end
    rst = 1'b0;
    cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
